mips_regfile_dumper: RTL and testbench

- Sequential reader for the 8x32 MIPS register file; the hardware counterpart of a memory dump.
- On a start pulse it walks register addresses FIRST_REG..LAST_REG through one register-file read port.
- Each word is streamed out on a valid/ready interface, tagged with its address, with a last flag.
- Sits beside the register file and shares its clock; used for debug readout and self-checking benches.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_regfile_dumper_if.sv | 37 +++
 rtl/mips_registers.sv | 36 +++
 rtl/mips_regfile_dumper.sv | 115 +++++++++++
 tb/tb_mips_regfile_dumper.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file definitions: widths and the dumper state encoding.
package mips_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/mips_regfile_dumper_if.sv
// Output word stream of the register-file dumper.
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid rises, out_data/out_addr/out_last hold until
// that transfer, except that a register-file write to the word's own address
// refreshes out_data so the consumer never sees a stale value. out_valid
// never depends on out_ready.
interface mips_regfile_dumper_if
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mips_registers.sv
// 8x32 MIPS register file: two combinational read ports, one write port
// committed on the rising edge.
module mips_registers
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_read_reg1,
  input  logic [ADDR_W-1:0] i_read_reg2,
  input  logic [ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_reg_write,
  output logic [DATA_W-1:0] o_read_data1,
  output logic [DATA_W-1:0] o_read_data2
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  // Clear on reset, otherwise commit the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_reg_write) begin
      r_regs[i_write_reg] <= i_write_data;
    end
  end

  assign o_read_data1 = r_regs[i_read_reg1];
  assign o_read_data2 = r_regs[i_read_reg2];

endmodule

// File: rtl/mips_regfile_dumper.sv
// Walks register addresses FIRST_REG..LAST_REG through one register-file
// read port and streams each word out tagged with its address. Writes seen
// on the register-file write port are forwarded into the held word so the
// dump stays coherent with the file.
module mips_regfile_dumper
  import mips_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [DATA_W-1:0]           rd_data,
  input  logic                        snoop_we,
  input  logic [ADDR_W-1:0]           snoop_addr,
  input  logic [DATA_W-1:0]           snoop_data,
  mips_regfile_dumper_if.master       out_if,
  output logic                        busy,
  output logic                        done,
  output dump_state_t                 o_dbg_state
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_word;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  logic w_snoop_hit;
  logic w_at_last;
  logic w_accept;

  assign w_snoop_hit = snoop_we && (snoop_addr == r_addr);
  assign w_at_last   = (r_addr == LAST_A);
  assign w_accept    = r_valid && out_if.out_ready;

  // Dump sequencer: address/word registers plus registered stream and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= FIRST_A;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      // Cancel: drop the stream, keep the last captured word, no done pulse.
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_addr  <= FIRST_A;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          // A write landing on this edge is the value the file will hold, so take it.
          r_word  <= w_snoop_hit ? snoop_data : rd_data;
          r_valid <= 1'b1;
          r_last  <= w_at_last;
          r_state <= SEND;
        end
        SEND: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_at_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              // Never issued from LAST_REG, so the address cannot wrap.
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= FETCH;
            end
          end else if (w_snoop_hit) begin
            r_word <= snoop_data;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_addr          = r_addr;
  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_word;
  assign out_if.out_addr  = r_addr;
  assign out_if.out_last  = r_last;
  assign busy             = r_busy;
  assign done             = r_done;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mips_regfile_dumper.sv
// Directed bench: a full-range dumper on read port 1 and a single-register
// dumper (6..6) on read port 2 of one register file, both snooping its write port.
module tb_mips_regfile_dumper;
  import mips_pkg::*;

  localparam int DW = REG_DATA_W;
  localparam int AW = REG_ADDR_W;
  localparam int WW = AW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, abort_a = 1'b0;
  logic          start_b = 1'b0, abort_b = 1'b0;
  logic          we      = 1'b0;
  logic [AW-1:0] waddr   = '0;
  logic [DW-1:0] wdata   = '0;

  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          busy_a, done_a, busy_b, done_b;
  dump_state_t   st_a, st_b;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] model [8];

  mips_regfile_dumper_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  mips_regfile_dumper_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  mips_registers #(.DATA_W(DW), .ADDR_W(AW)) u_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read_reg1  (rd_addr_a),
    .i_read_reg2  (rd_addr_b),
    .i_write_reg  (waddr),
    .i_write_data (wdata),
    .i_reg_write  (we),
    .o_read_data1 (rd_data_a),
    .o_read_data2 (rd_data_b)
  );

  mips_regfile_dumper #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(7)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .abort       (abort_a),
    .rd_addr     (rd_addr_a),
    .rd_data     (rd_data_a),
    .snoop_we    (we),
    .snoop_addr  (waddr),
    .snoop_data  (wdata),
    .out_if      (if_a.master),
    .busy        (busy_a),
    .done        (done_a),
    .o_dbg_state (st_a)
  );

  mips_regfile_dumper #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(6), .LAST_REG(6)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .abort       (abort_b),
    .rd_addr     (rd_addr_b),
    .rd_data     (rd_data_b),
    .snoop_we    (we),
    .snoop_addr  (waddr),
    .snoop_data  (wdata),
    .out_if      (if_b.master),
    .busy        (busy_b),
    .done        (done_b),
    .o_dbg_state (st_b)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    model[a] = d;
    step();
    we = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) write_reg(AW'(i), DW'(32'h1111_1111 * i));
  endtask

  task automatic expect_words(input int first, input int last);
    for (int a = first; a <= last; a++)
      exp_q.push_back({(a == last), AW'(a), model[a]});
  endtask

  function automatic logic [WW-1:0] obs_a();
    return {if_a.out_last, if_a.out_addr, if_a.out_data};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [WW-1:0] idle_word;
    idle_word = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_a.out_valid); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
    checks++; if (rd_addr_a !== 3'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr_a); end
    checks++; if (obs_a() !== idle_word) begin errors++; $display("FAIL reset_out: got %h expected %h", obs_a(), idle_word); end
    checks++; if (st_a !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st_a, IDLE); end
    checks++; if (rd_addr_b !== 3'd6) begin errors++; $display("FAIL reset_rd_addr_b: got %0d expected 6", rd_addr_b); end
  endtask

  // Full 0..7 dump with out_ready held high; optionally pokes start mid-dump.
  task automatic test_full_dump(input bit poke_start, input string tag);
    logic [WW-1:0] exp;
    int first_valid, done_cyc;
    first_valid = -1; done_cyc = -1;
    exp_q.delete();
    if_a.out_ready = 1'b1;
    expect_words(0, 7);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1 || if_a.out_valid !== 1'b0) begin errors++; $display("FAIL %s_c0: got busy=%b valid=%b expected busy=1 valid=0", tag, busy_a, if_a.out_valid); end
    for (int c = 1; c <= 40; c++) begin
      start_a = poke_start && (c == 5 || c == 12);
      step();
      if (if_a.out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL %s_extra: got %h expected no word", tag, obs_a());
        end else begin
          exp = exp_q.pop_front();
          checks++; if (obs_a() !== exp) begin errors++; $display("FAIL %s_word: got %h expected %h", tag, obs_a(), exp); end
        end
      end
      if (done_a) begin done_cyc = c; break; end
    end
    start_a = 1'b0;
    checks++; if (first_valid !== 1) begin errors++; $display("FAIL %s_first_valid: got %0d expected 1", tag, first_valid); end
    checks++; if (done_cyc !== 16) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 16", tag, done_cyc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL %s_missing: got %0d left expected 0", tag, exp_q.size()); end
    step();
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL %s_after: got busy=%b done=%b expected 0 0", tag, busy_a, done_a); end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] exp;
    bit stalled, done_seen;
    stalled = 1'b0; done_seen = 1'b0;
    exp_q.delete();
    if_a.out_ready = 1'b1;
    expect_words(0, 7);
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c <= 50 && !done_seen; c++) begin
      step();
      if (if_a.out_valid) begin
        if (if_a.out_addr == 3'd3 && !stalled) begin
          if_a.out_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_addr !== 3'd3 || if_a.out_data !== 32'h3333_3333) begin
              errors++; $display("FAIL bp_hold: got valid=%b addr=%0d data=%h expected 1 3 33333333", if_a.out_valid, if_a.out_addr, if_a.out_data);
            end
          end
          if_a.out_ready = 1'b1;
          stalled = 1'b1;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++; if (obs_a() !== exp) begin errors++; $display("FAIL bp_word: got %h expected %h", obs_a(), exp); end
      end
      if (done_a) done_seen = 1'b1;
    end
    checks++; if (!done_seen || exp_q.size() != 0) begin errors++; $display("FAIL bp_end: got done=%b left=%0d expected 1 0", done_seen, exp_q.size()); end
    step();
  endtask

  task automatic test_snoop();
    bit found;
    found = 1'b0;
    if_a.out_ready = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (if_a.out_valid && if_a.out_addr == 3'd2) begin found = 1'b1; break; end
      step();
    end
    if_a.out_ready = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL snoop_reach: got no addr2 word expected one"); end
    write_reg(3'd5, 32'hCAFE_F00D);
    checks++; if (if_a.out_data !== 32'h2222_2222) begin errors++; $display("FAIL snoop_other: got %h expected 22222222", if_a.out_data); end
    write_reg(3'd2, 32'hDEAD_BEEF);
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL snoop_hit: got valid=%b data=%h expected 1 deadbeef", if_a.out_valid, if_a.out_data); end
    if_a.out_ready = 1'b1;
    step();
    checks++; if (if_a.out_valid !== 1'b0 || rd_addr_a !== 3'd3) begin errors++; $display("FAIL snoop_fetch3: got valid=%b rd_addr=%0d expected 0 3", if_a.out_valid, rd_addr_a); end
    step();
    checks++; if (if_a.out_data !== 32'h3333_3333) begin errors++; $display("FAIL snoop_word3: got %h expected 33333333", if_a.out_data); end
    step(); step();
    checks++; if (if_a.out_data !== 32'h4444_4444) begin errors++; $display("FAIL snoop_word4: got %h expected 44444444", if_a.out_data); end
    step();
    checks++; if (st_a !== FETCH || rd_addr_a !== 3'd5) begin errors++; $display("FAIL snoop_fetch5: got state=%0d rd_addr=%0d expected %0d 5", st_a, rd_addr_a, FETCH); end
    write_reg(3'd5, 32'hF00D_F00D);
    checks++; if ({if_a.out_addr, if_a.out_data} !== {3'd5, 32'hF00D_F00D}) begin errors++; $display("FAIL snoop_fetch_fwd: got %0d/%h expected 5/f00df00d", if_a.out_addr, if_a.out_data); end
    abort_a = 1'b1; step(); abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || if_a.out_valid !== 1'b0) begin errors++; $display("FAIL snoop_abort: got busy=%b valid=%b expected 0 0", busy_a, if_a.out_valid); end
    write_reg(3'd2, 32'h2222_2222);
    write_reg(3'd5, 32'h5555_5555);
  endtask

  task automatic test_abort();
    bit found, saw_done;
    found = 1'b0; saw_done = 1'b0;
    if_a.out_ready = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (if_a.out_valid && if_a.out_addr == 3'd4) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach: got no addr4 word expected one"); end
    abort_a = 1'b1; step(); abort_a = 1'b0;
    checks++; if (if_a.out_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL abort_drop: got valid=%b busy=%b done=%b expected 0 0 0", if_a.out_valid, busy_a, done_a); end
    checks++; if (if_a.out_data !== 32'h4444_4444) begin errors++; $display("FAIL abort_word_kept: got %h expected 44444444", if_a.out_data); end
    for (int k = 0; k < 3; k++) begin step(); if (done_a) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done: got done pulse expected none"); end
    start_a = 1'b1; abort_a = 1'b1; step(); start_a = 1'b0; abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || st_a !== IDLE) begin errors++; $display("FAIL abort_wins: got busy=%b state=%0d expected 0 %0d", busy_a, st_a, IDLE); end
    start_a = 1'b1; step(); start_a = 1'b0;
    step();
    checks++; if ({if_a.out_valid, if_a.out_addr, if_a.out_data} !== {1'b1, 3'd0, 32'h0}) begin errors++; $display("FAIL abort_restart: got valid=%b addr=%0d data=%h expected 1 0 00000000", if_a.out_valid, if_a.out_addr, if_a.out_data); end
    abort_a = 1'b1; step(); abort_a = 1'b0;
  endtask

  task automatic test_single_reg();
    int words, done_c;
    words = 0; done_c = -1;
    if_b.out_ready = 1'b1;
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (if_b.out_valid) begin
        words++;
        checks++;
        if ({if_b.out_last, if_b.out_addr, if_b.out_data} !== {1'b1, 3'd6, 32'h6666_6666}) begin
          errors++; $display("FAIL single_word: got last=%b addr=%0d data=%h expected 1 6 66666666", if_b.out_last, if_b.out_addr, if_b.out_data);
        end
      end
      if (done_b) begin done_c = c; break; end
    end
    checks++; if (words !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", words); end
    checks++; if (done_c !== 2) begin errors++; $display("FAIL single_done: got %0d expected 2", done_c); end
    step();
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", busy_b); end
  endtask

  task automatic test_async_reset();
    if_a.out_ready = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    step(); step(); step(); step();
    checks++; if (st_a !== FETCH || rd_addr_a !== 3'd2 || if_a.out_data !== 32'h1111_1111) begin errors++; $display("FAIL arst_pre: got state=%0d rd_addr=%0d data=%h expected %0d 2 11111111", st_a, rd_addr_a, if_a.out_data, FETCH); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0 || if_a.out_valid !== 1'b0 || if_a.out_last !== 1'b0 || st_a !== IDLE) begin errors++; $display("FAIL arst_flags: got busy=%b valid=%b last=%b state=%0d expected 0 0 0 %0d", busy_a, if_a.out_valid, if_a.out_last, st_a, IDLE); end
    checks++; if (rd_addr_a !== 3'd0 || if_a.out_addr !== 3'd0 || if_a.out_data !== 32'h0) begin errors++; $display("FAIL arst_regs: got rd_addr=%0d addr=%0d data=%h expected 0 0 00000000", rd_addr_a, if_a.out_addr, if_a.out_data); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    step();
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL arst_after: got busy=%b done=%b expected 0 0", busy_a, done_a); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clk);
    test_reset();
    preload();
    test_full_dump(1'b0, "full");
    test_backpressure();
    test_snoop();
    test_abort();
    test_single_reg();
    test_full_dump(1'b1, "busy_start");
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
